bram_sdp_clr: RTL and testbench

//   Simple-dual-port block RAM (one write port, one read port) with registered

---
 rtl/bram_sdp_clr_pkg.sv | 11 +
 rtl/bram_sdp_array.sv | 35 +++
 rtl/bram_sdp_clr.sv | 109 ++++++++++
 tb/tb_bram_sdp_clr.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bram_sdp_clr_pkg.sv
// Shared definitions for the clearable simple-dual-port RAM: FSM state encodings
// and the default geometry used by the CPU top level.
package bram_sdp_clr_pkg;

    localparam logic [0:0] BRAM_ST_CLEAR = 1'b0;
    localparam logic [0:0] BRAM_ST_RUN   = 1'b1;

    localparam int BRAM_DEF_WIDTH      = 16;
    localparam int BRAM_DEF_ADDR_WIDTH = 8;

endpackage

// File: rtl/bram_sdp_array.sv
// Bare simple-dual-port array: one synchronous write port and one registered,
// enabled read port. No reset, so yosys maps it onto SB_RAM40_4K.
module bram_sdp_array
    import bram_sdp_clr_pkg::*;
#(
    parameter int WIDTH      = BRAM_DEF_WIDTH,
    parameter int ADDR_WIDTH = BRAM_DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its read register carry no reset; a reset term would
    // stop the tools from mapping them onto block RAM. Contents are initialised
    // by the clear engine in the parent instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        // A same-address read in the write cycle sees the old word (read-first).
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bram_sdp_clr.sv
// Simple-dual-port RAM with registered read, read-valid strobe and a clear engine
// that fills every word with INIT_VALUE. Define BRAM_WRITE_FORWARD_EN for write-first collisions.
module bram_sdp_clr
    import bram_sdp_clr_pkg::*;
#(
    parameter int                       WIDTH      = BRAM_DEF_WIDTH,
    parameter int                       ADDR_WIDTH = BRAM_DEF_ADDR_WIDTH,
    parameter logic [WIDTH-1:0]         INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clearing;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [WIDTH-1:0]      ram_wdata;
    logic [WIDTH-1:0]      ram_rdata;
    logic                  read_seen;

    assign clearing = (state == BRAM_ST_CLEAR);
    assign ready    = ~clearing;
    assign wr_acc   = ready & wr_en;
    assign rd_acc   = ready & rd_en;

    assign ram_we    = clearing | wr_acc;
    assign ram_waddr = clearing ? clr_addr   : wr_addr;
    assign ram_wdata = clearing ? INIT_VALUE : wr_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BRAM_ST_CLEAR;
            clr_addr <= '0;
        end else if (clearing) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == LAST_ADDR) begin
                state <= BRAM_ST_RUN;
            end
        end else if (clear_req) begin
            state    <= BRAM_ST_CLEAR;
            clr_addr <= '0;
        end
    end

    // The array read register is not reset, so rd_data is forced to zero until
    // the first read after reset has completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            read_seen <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                read_seen <= 1'b1;
            end
        end
    end

    bram_sdp_array #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_acc),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

`ifdef BRAM_WRITE_FORWARD_EN
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;

    // Collision flag and data are updated only on reads so rd_data still holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else if (rd_acc) begin
            fwd_hit  <= wr_acc & (wr_addr == rd_addr);
            fwd_data <= wr_data;
        end
    end

    assign rd_data = !read_seen ? '0 : (fwd_hit ? fwd_data : ram_rdata);
`else
    assign rd_data = read_seen ? ram_rdata : '0;
`endif

endmodule

// File: tb/tb_bram_sdp_clr.sv
// Self-checking bench for bram_sdp_clr: a behavioural memory model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_bram_sdp_clr;

    localparam int          WIDTH = 16;
    localparam int          AW    = 8;
    localparam int          DEPTH = 1 << AW;
    localparam logic [15:0] INIT  = 16'h0000;
`ifdef BRAM_WRITE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_req = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [15:0]   wr_data = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [15:0]   rd_data;
    logic          rd_valid;
    logic          ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bram_sdp_clr #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (AW),
        .INIT_VALUE (INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ready     (ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a clear is "instantly" applied to the model memory and
    // simply blocks user traffic for DEPTH cycles.
    logic [15:0] m_mem [DEPTH];
    int          clear_left = DEPTH;
    logic        m_valid = 1'b0;
    logic [15:0] m_data = '0;

    always @(posedge clk) begin
        if (rst) begin
            clear_left <= DEPTH;
            m_valid    <= 1'b0;
            m_data     <= '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= INIT;
        end else if (clear_left > 0) begin
            clear_left <= clear_left - 1;
            m_valid    <= 1'b0;
        end else begin
            m_valid <= rd_en;
            if (rd_en) begin
                m_data <= (FWD && wr_en && wr_addr == rd_addr) ? wr_data : m_mem[rd_addr];
            end
            if (wr_en) m_mem[wr_addr] <= wr_data;
            if (clear_req) begin
                clear_left <= DEPTH;
                for (int i = 0; i < DEPTH; i++) m_mem[i] <= INIT;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_ready", {31'b0, ready}, 32'd0);
            check("rst_valid", {31'b0, rd_valid}, 32'd0);
            check("rst_data", {16'b0, rd_data}, 32'd0);
        end else begin
            check("ready", {31'b0, ready}, {31'b0, clear_left == 0});
            check("rd_valid", {31'b0, rd_valid}, {31'b0, m_valid});
            check("rd_data", {16'b0, rd_data}, {16'b0, m_data});
        end
    end

    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [15:0] wd,
                        input logic re, input logic [AW-1:0] ra, input logic cr);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra; clear_req = cr;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [7:0] a;
        // 1: reset, clear timing, initial contents
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(255);
        check("t1_ready_low", {31'b0, ready}, 32'd0);
        idle(1);
        check("t1_ready_high", {31'b0, ready}, 32'd1);
        step(1'b0, '0, '0, 1'b1, 8'h00, 1'b0);
        check("t1_rd00", {15'b0, rd_valid, rd_data}, 32'h0001_0000);
        step(1'b0, '0, '0, 1'b1, 8'h7F, 1'b0);
        check("t1_rd7f", {15'b0, rd_valid, rd_data}, 32'h0001_0000);
        step(1'b0, '0, '0, 1'b1, 8'hFF, 1'b0);
        check("t1_rdff", {15'b0, rd_valid, rd_data}, 32'h0001_0000);

        // 2: write then read, hold behaviour
        step(1'b1, 8'h12, 16'hBEEF, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 8'h12, 1'b0);
        check("t2_rd", {15'b0, rd_valid, rd_data}, 32'h0001_BEEF);
        idle(3);
        check("t2_hold", {15'b0, rd_valid, rd_data}, 32'h0000_BEEF);

        // 3: same-cycle collision
        step(1'b1, 8'h40, 16'h1234, 1'b1, 8'h40, 1'b0);
        check("t3_collide", {16'b0, rd_data}, FWD ? 32'h1234 : 32'h0000);
        step(1'b0, '0, '0, 1'b1, 8'h40, 1'b0);
        check("t3_after", {16'b0, rd_data}, 32'h1234);

        // 4: fill, clear_req, traffic ignored during clear
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 16'(i) ^ 16'hA5A5, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 8'h33, 1'b1);
        check("t4_req_read", {15'b0, rd_valid, rd_data}, 32'h0001_A596);
        check("t4_ready_drop", {31'b0, ready}, 32'd0);
        for (int i = 0; i < DEPTH - 1; i++)
            step(1'b1, 8'($urandom), 16'($urandom), 1'b1, 8'($urandom), 1'b0);
        check("t4_still_clear", {31'b0, ready}, 32'd0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1, 8'(i), 1'b0);
        idle(1);

        // 5: reset in the middle of a clear
        step(1'b0, '0, '0, 1'b0, '0, 1'b1);
        idle(100);
        step(1'b0, '0, '0, 1'b1, 8'h12, 1'b0);
        rst = 1'b1;
        #1;
        check("t5_ready", {31'b0, ready}, 32'd0);
        check("t5_valid_lost", {31'b0, rd_valid}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(255);
        check("t5_ready_low", {31'b0, ready}, 32'd0);
        idle(1);
        check("t5_ready_high", {31'b0, ready}, 32'd1);

        // 6: stride-3 back-to-back reads after a fill
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 16'(i * 257 + 7), 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            a = 8'(i * 3);
            step(1'b0, '0, '0, 1'b1, a, 1'b0);
        end
        check("t6_last", {15'b0, rd_valid, rd_data}, {15'b0, 1'b1, 16'(8'hFD * 257 + 7)});

        // Random traffic with rare clear requests
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 1) == 1, 8'($urandom_range(0, 15)), 16'($urandom),
                 $urandom_range(0, 2) != 0, 8'($urandom_range(0, 15)),
                 $urandom_range(0, 399) == 0);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
